fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned request at a time and
// buffers up to two returned instructions for decode.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [31:0] inst,
    output logic [63:0] pc,
    output logic        inst_valid
);

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [63:0] ALIGN_MASK = ~64'h3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] fpc_q, fpc_d;
    logic [63:0] outAddr_q, outAddr_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic [63:0] fifoAddr_q [2];
    logic [31:0] fifoWord_q [2];

    logic grant;
    logic push;
    logic pop;
    logic tailIdx;

    assign inst_valid = (count_q != 2'd0);
    assign inst       = inst_valid ? fifoWord_q[head_q] : NOP;
    assign pc         = inst_valid ? fifoAddr_q[head_q] : 64'h0;

    // Gating with rst keeps the request low while the unit sits in reset.
    assign imem_req  = ~rst && (state_q == ST_RUN) && ~redirect && (count_q != 2'd2);
    assign imem_addr = fpc_q;

    assign grant   = imem_req & imem_gnt;
    assign push    = (state_q == ST_WAIT) & imem_rvalid & ~redirect;
    assign pop     = inst_valid & ~stall & ~redirect;
    assign tailIdx = head_q ^ count_q[0];

    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        outAddr_d = outAddr_q;
        count_d   = count_q;
        head_d    = head_q;

        case (state_q)
            ST_RUN: begin
                if (grant) begin
                    state_d   = ST_WAIT;
                    outAddr_d = fpc_q;
                    fpc_d     = fpc_q + 64'd4;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_RUN;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // A redirect flushes everything buffered and overrides any FIFO movement.
        if (redirect) begin
            fpc_d   = redirect_pc & ALIGN_MASK;
            count_d = 2'd0;
            head_d  = 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            head_d = head_q ^ pop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            fpc_q     <= RESET_PC & ALIGN_MASK;
            outAddr_q <= 64'h0;
            count_q   <= 2'd0;
            head_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            outAddr_q <= outAddr_d;
            count_q   <= count_d;
            head_q    <= head_d;
        end
    end

    // Payload storage needs no reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr_q[tailIdx] <= outAddr_q;
            fifoWord_q[tailIdx] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers grants, a monitor
// compares every instruction decode consumes against queued expectations.
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_valid;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;

    int          rspDelay = 1;
    bit          memPending = 1'b0;
    int          memCnt = 0;
    logic [63:0] memAddr = 64'h0;
    int          grantCount = 0;
    bit          ovrEn = 1'b0;
    logic [63:0] ovrAddr = 64'h0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .pc          (pc),
        .inst_valid  (inst_valid)
    );

    function automatic logic [31:0] memData(input logic [63:0] a);
        if (ovrEn && a == ovrAddr) return 32'hDEADBEEF;
        return a[31:0] ^ 32'h5A5A0013;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [63:0] a);
        exp_t e;
        e.pc   = a;
        e.inst = memData(a);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic s, input logic g, input logic r, input logic [63:0] rpc);
        stall       = s;
        imem_gnt    = g;
        redirect    = r;
        redirect_pc = rpc;
    endtask

    task automatic holdReset();
        #1 rst = 1'b1;
        expQ.delete();
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic releaseReset();
        rst = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s drain: got %0d outstanding, expected 0", name, expQ.size());
        end
    endtask

    // Memory model: grant seen before an edge, response rspDelay cycles later.
    initial begin : memModel
        bit          g;
        logic [63:0] a;
        forever begin
            @(negedge clk);
            g = !rst && imem_req && imem_gnt;
            a = imem_addr;
            if (rst) grantCount = 0;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (g) begin
                memPending = 1'b1;
                memCnt     = rspDelay;
                memAddr    = a;
                grantCount++;
            end
            if (memPending) begin
                memCnt--;
                if (memCnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memData(memAddr);
                    memPending  = 1'b0;
                end
            end
        end
    end

    // Monitor: an instruction is consumed at the next edge when valid and unstalled.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && !stall && !redirect && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb pc", pc, e.pc);
                checkOutput("sb inst", 64'(inst), 64'(e.inst));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit found;

        // Streaming fetch with single-cycle memory.
        holdReset();
        rspDelay = 1;
        ovrEn    = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("rst inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("rst inst", 64'(inst), 64'(NOP));
        checkOutput("rst pc", pc, 64'h0);
        checkOutput("rst imem_req", 64'(imem_req), 64'd0);
        checkOutput("rst imem_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 8; i++) pushExp(64'(i * 4));
        nextCycle();
        releaseReset();
        @(negedge clk);
        checkOutput("first req", 64'(imem_req), 64'd1);
        checkOutput("first addr", imem_addr, RESET_PC);
        checkOutput("c1 inst_valid", 64'(inst_valid), 64'd0);
        @(negedge clk);
        checkOutput("c2 inst_valid", 64'(inst_valid), 64'd0);
        @(negedge clk);
        checkOutput("c3 inst_valid", 64'(inst_valid), 64'd1);
        waitDrain("stream", 100);

        // Stall held: FIFO fills with two words and back-pressures fetch.
        holdReset();
        rspDelay = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        releaseReset();
        repeat (10) @(negedge clk);
        checkOutput("stall grants", 64'(grantCount), 64'd2);
        checkOutput("stall imem_req", 64'(imem_req), 64'd0);
        checkOutput("stall imem_addr", imem_addr, 64'h8);
        checkOutput("stall inst_valid", 64'(inst_valid), 64'd1);
        checkOutput("stall pc", pc, 64'h0);
        checkOutput("stall inst", 64'(inst), 64'(memData(64'h0)));
        pushExp(64'h0);
        pushExp(64'h4);
        pushExp(64'h8);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
        waitDrain("stall release", 60);

        // Redirect while the fetch of 0x8 is outstanding; its response is dropped.
        holdReset();
        rspDelay = 2;
        ovrEn    = 1'b1;
        ovrAddr  = 64'h8;
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
        pushExp(64'h0);
        pushExp(64'h4);
        pushExp(64'h1000);
        releaseReset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            nextCycle();
            if (memPending && memAddr == 64'h8) found = 1'b1;
        end
        checkOutput("drop saw grant 8", 64'(found), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h1000);
        @(negedge clk);
        checkOutput("drop redirect req", 64'(imem_req), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("drop rvalid cycle req", 64'(imem_req), 64'd0);
        checkOutput("drop inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("drop imem_addr", imem_addr, 64'h1000);
        waitDrain("drop", 60);
        ovrEn = 1'b0;

        // Redirect in the same cycle as the response.
        holdReset();
        rspDelay = 1;
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
        pushExp(64'h2000);
        releaseReset();
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h2000);
        @(negedge clk);
        checkOutput("redir+rvalid req", 64'(imem_req), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("redir+rvalid inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("redir+rvalid inst", 64'(inst), 64'(NOP));
        checkOutput("redir+rvalid pc", pc, 64'h0);
        checkOutput("redir+rvalid req next", 64'(imem_req), 64'd1);
        checkOutput("redir+rvalid addr next", imem_addr, 64'h2000);
        waitDrain("redir+rvalid", 40);

        // Misaligned redirect target and fetch PC wraparound.
        holdReset();
        rspDelay = 1;
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h1002);
        pushExp(64'hFFFFFFFF_FFFFFFFC);
        pushExp(64'h0);
        releaseReset();
        @(negedge clk);
        checkOutput("align redirect req", 64'(imem_req), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("align req", 64'(imem_req), 64'd1);
        checkOutput("align addr", imem_addr, 64'h1000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFC);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("wrap addr", imem_addr, 64'hFFFFFFFF_FFFFFFFC);
        nextCycle();
        @(negedge clk);
        checkOutput("wrap next addr", imem_addr, 64'h0);
        checkOutput("wrap wait req", 64'(imem_req), 64'd0);
        waitDrain("wrap", 40);

        // Asynchronous reset with one entry buffered and a fetch outstanding.
        holdReset();
        rspDelay = 3;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        releaseReset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (inst_valid && memPending) found = 1'b1;
        end
        checkOutput("midrst setup", 64'(found), 64'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("midrst inst", 64'(inst), 64'(NOP));
        checkOutput("midrst pc", pc, 64'h0);
        checkOutput("midrst req", 64'(imem_req), 64'd0);
        repeat (5) @(posedge clk);
        #2;
        expQ.delete();
        pushExp(64'h0);
        pushExp(64'h4);
        pushExp(64'h8);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
        releaseReset();
        @(negedge clk);
        checkOutput("midrst restart req", 64'(imem_req), 64'd1);
        checkOutput("midrst restart addr", imem_addr, RESET_PC);
        checkOutput("midrst restart valid", 64'(inst_valid), 64'd0);
        waitDrain("midrst", 80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
